// File: rtl/process_scheduler_pkg.sv
// process_scheduler_pkg
//   Shared definitions for the round-robin process scheduler:
//   - QUANTUM_W : width of the quantum register and the slice countdown
//   - sched_state_t : scheduler FSM states
//   - pid_width() : process-id width for a given context count (minimum 1)
package process_scheduler_pkg;

  localparam int QUANTUM_W = 16;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SAVE,
    ST_SELECT,
    ST_RESTORE,
    ST_IDLE
  } sched_state_t;

  function automatic int pid_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/process_scheduler_if.sv
// process_scheduler_if
//   Bundle between the control unit / PC bank and the scheduler.
//   Control side -> scheduler:
//     halt        datapath stall, freezes the slice countdown
//     quantumLoad load a new quantum from quantumIn[15:0]
//     quantumIn   new quantum value
//     procStart   mark procStartId alive and fresh
//     procStartId process to start
//     yieldReq    running process gives up its slice
//     exitReq     running process terminates
//   Scheduler -> control side / PC bank:
//     pId         running process index (PC bank select)
//     freeze      datapath must not update state this cycle
//     pcReset     one-cycle request to clear the PC of pId
//     ctxSwitch   one-cycle pulse, pId changed this cycle
//     idle        no process alive
//   master: driven by the control unit (or a testbench); slave: the scheduler.
interface process_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PID_W      = 1
);

  logic                  halt;
  logic                  quantumLoad;
  logic [DATA_WIDTH-1:0] quantumIn;
  logic                  procStart;
  logic [PID_W-1:0]      procStartId;
  logic                  yieldReq;
  logic                  exitReq;
  logic [PID_W-1:0]      pId;
  logic                  freeze;
  logic                  pcReset;
  logic                  ctxSwitch;
  logic                  idle;

  modport master (
    output halt, quantumLoad, quantumIn, procStart, procStartId, yieldReq, exitReq,
    input  pId, freeze, pcReset, ctxSwitch, idle
  );

  modport slave (
    input  halt, quantumLoad, quantumIn, procStart, procStartId, yieldReq, exitReq,
    output pId, freeze, pcReset, ctxSwitch, idle
  );

endinterface

// File: rtl/process_scheduler_rr_next_select.sv
// rr_next_select
//   Combinational wrap-around priority pick. Returns the first set bit of
//   alive_i strictly after cur_i in ascending order, wrapping, with cur_i
//   itself considered last.
//   alive_i : alive mask, one bit per process
//   cur_i   : currently running process id
//   next_o  : selected process id (cur_i when nothing is alive)
//   valid_o : at least one process alive
module rr_next_select #(
  parameter int NPROCESS = 2,
  parameter int PID_W    = 1
) (
  input  logic [NPROCESS-1:0] alive_i,
  input  logic [PID_W-1:0]    cur_i,
  output logic [PID_W-1:0]    next_o,
  output logic                valid_o
);

  always_comb begin
    int unsigned cand;
    next_o  = cur_i;
    valid_o = 1'b0;
    cand    = 0;
    // offset NPROCESS lands back on cur_i, giving it the lowest priority
    for (int unsigned off = 1; off <= NPROCESS; off++) begin
      cand = (32'(cur_i) + off) % NPROCESS;
      if (!valid_o && alive_i[cand[PID_W-1:0]]) begin
        next_o  = cand[PID_W-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// process_scheduler
//   Round-robin, time-sliced scheduler owning the process-select index of
//   the per-process PC bank. A slice of Q cycles gives exactly Q unstalled
//   RUN cycles; a switch costs SAVE/SELECT/RESTORE (3 frozen cycles), a
//   self-resume SAVE/SELECT (2). Quantum 0 disables preemption.
//   Ports:
//     clock : system clock, all state on the rising edge
//     reset : asynchronous active-low reset
//     sch   : process_scheduler_if slave (requests in, pId/freeze/... out)
//   All outputs are decodes of registered state.
module process_scheduler
  import process_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int NPROCESS        = 2,
  parameter int QUANTUM_DEFAULT = 16,
  parameter int PID_W           = pid_width(NPROCESS)
) (
  input logic               clock,
  input logic               reset,
  process_scheduler_if.slave sch
);

  localparam logic [PID_W:0] NPROC_L = (PID_W + 1)'(NPROCESS);

  sched_state_t         state_q, state_d;
  logic [PID_W-1:0]     pid_q, pid_d;
  logic [NPROCESS-1:0]  alive_q, alive_d;
  logic [NPROCESS-1:0]  fresh_q, fresh_d;
  logic [QUANTUM_W-1:0] quantum_q, quantum_d;
  logic [QUANTUM_W-1:0] count_q, count_d;

  logic [PID_W-1:0]     sel_next;
  logic                 sel_valid;
  logic                 start_ok;
  logic                 exit_ok;
  logic                 expire;

  generate
    if (DATA_WIDTH > QUANTUM_W) begin : g_unused_hi
      logic unused_quantum_hi;
      assign unused_quantum_hi = ^sch.quantumIn[DATA_WIDTH-1:QUANTUM_W];
    end
  endgenerate

  rr_next_select #(
    .NPROCESS (NPROCESS),
    .PID_W    (PID_W)
  ) u_rr_next_select (
    .alive_i (alive_q),
    .cur_i   (pid_q),
    .next_o  (sel_next),
    .valid_o (sel_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      pid_q     <= '0;
      alive_q   <= NPROCESS'(1);
      fresh_q   <= '0;
      quantum_q <= QUANTUM_W'(QUANTUM_DEFAULT);
      count_q   <= QUANTUM_W'(QUANTUM_DEFAULT);
    end else begin
      state_q   <= state_d;
      pid_q     <= pid_d;
      alive_q   <= alive_d;
      fresh_q   <= fresh_d;
      quantum_q <= quantum_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pid_d     = pid_q;
    count_d   = count_q;
    alive_d   = alive_q;
    fresh_d   = fresh_q;
    // the countdown reloads below use quantum_q, so a load only affects the next slice
    quantum_d = sch.quantumLoad ? sch.quantumIn[QUANTUM_W-1:0] : quantum_q;

    start_ok  = sch.procStart && ({1'b0, sch.procStartId} < NPROC_L)
                && !alive_q[sch.procStartId];
    exit_ok   = (state_q == ST_RUN) && sch.exitReq;
    // a zero countdown never reaches 1, so quantum 0 means no preemption
    expire    = (count_q == QUANTUM_W'(1)) && !sch.halt;

    case (state_q)
      ST_RUN: begin
        if (!sch.halt && (count_q != '0)) count_d = count_q - QUANTUM_W'(1);
        if (exit_ok || sch.yieldReq || expire) state_d = ST_SAVE;
      end
      ST_SAVE: state_d = ST_SELECT;
      ST_SELECT: begin
        if (!sel_valid) begin
          state_d = ST_IDLE;
        end else if (sel_next == pid_q) begin
          state_d = ST_RUN;
          count_d = quantum_q;
        end else begin
          // pId moves on entry to RESTORE so the PC bank sees it with ctxSwitch
          state_d = ST_RESTORE;
          pid_d   = sel_next;
        end
      end
      ST_RESTORE: begin
        state_d        = ST_RUN;
        count_d        = quantum_q;
        fresh_d[pid_q] = 1'b0;
      end
      ST_IDLE: if (|alive_q) state_d = ST_SELECT;
      default: state_d = ST_RUN;
    endcase

    if (start_ok) begin
      alive_d[sch.procStartId] = 1'b1;
      fresh_d[sch.procStartId] = 1'b1;
    end
    // applied after the start so an exit on the same id wins
    if (exit_ok) alive_d[pid_q] = 1'b0;
  end

  always_comb begin
    sch.pId       = pid_q;
    sch.freeze    = (state_q != ST_RUN);
    sch.idle      = (state_q == ST_IDLE);
    sch.ctxSwitch = (state_q == ST_RESTORE);
    sch.pcReset   = (state_q == ST_RESTORE) && fresh_q[pid_q];
  end

endmodule

// File: tb/tb_process_scheduler.sv
// tb_process_scheduler
//   Directed bench for process_scheduler (NPROCESS=2, Q=16). A behavioural
//   model tracks slice usage, alive/fresh sets and the switch sequence; a
//   compare process checks every output on every falling edge, and the
//   stimulus process adds literal checks at hand-computed cycles.
module tb_process_scheduler;

  localparam int NP = 2;
  localparam int PW = 1;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  process_scheduler_if #(.DATA_WIDTH(DW), .PID_W(PW)) sch ();

  process_scheduler #(
    .DATA_WIDTH      (DW),
    .NPROCESS        (NP),
    .QUANTUM_DEFAULT (16),
    .PID_W           (PW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sch   (sch)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_RUN = 0, M_SAVE = 1, M_SEL = 2, M_RES = 3, M_IDLE = 4;
  int m_ph;
  int m_pid;
  bit m_alive[NP];
  bit m_fresh[NP];
  int m_q;
  int m_slice;
  int m_used;

  task automatic m_init();
    m_ph = M_RUN;
    m_pid = 0;
    for (int i = 0; i < NP; i++) begin
      m_alive[i] = (i == 0);
      m_fresh[i] = 1'b0;
    end
    m_q = 16;
    m_slice = 16;
    m_used = 0;
  endtask

  task automatic m_step();
    int nq;
    int pick;
    bit st_ok;
    bit ex_ok;
    bit done;
    nq    = sch.quantumLoad ? int'(sch.quantumIn[15:0]) : m_q;
    st_ok = sch.procStart && !m_alive[sch.procStartId];
    ex_ok = (m_ph == M_RUN) && sch.exitReq;
    pick  = -1;
    case (m_ph)
      M_RUN: begin
        done = ex_ok || sch.yieldReq ||
               (m_slice != 0 && !sch.halt && m_used + 1 == m_slice);
        if (!sch.halt) m_used++;
        if (done) m_ph = M_SAVE;
      end
      M_SAVE: m_ph = M_SEL;
      M_SEL: begin
        for (int off = NP; off >= 1; off--)
          if (m_alive[(m_pid + off) % NP]) pick = (m_pid + off) % NP;
        if (pick < 0) m_ph = M_IDLE;
        else begin
          m_ph = (pick == m_pid) ? M_RUN : M_RES;
          if (pick == m_pid) begin
            m_slice = m_q;
            m_used = 0;
          end
          m_pid = pick;
        end
      end
      M_RES: begin
        m_fresh[m_pid] = 1'b0;
        m_ph = M_RUN;
        m_slice = m_q;
        m_used = 0;
      end
      default: begin
        for (int i = 0; i < NP; i++) if (m_alive[i]) m_ph = M_SEL;
      end
    endcase
    if (st_ok) begin
      m_alive[sch.procStartId] = 1'b1;
      m_fresh[sch.procStartId] = 1'b1;
    end
    if (ex_ok) m_alive[m_pid] = 1'b0;
    m_q = nq;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) m_init();
    else m_step();
  end

  always @(negedge clock) begin
    chk("pId", 32'(sch.pId), 32'(m_pid));
    chk("freeze", 32'(sch.freeze), 32'(m_ph != M_RUN));
    chk("idle", 32'(sch.idle), 32'(m_ph == M_IDLE));
    chk("ctxSwitch", 32'(sch.ctxSwitch), 32'(m_ph == M_RES));
    chk("pcReset", 32'(sch.pcReset), 32'(m_ph == M_RES && m_fresh[m_pid]));
  end

  // ---------------- directed stimulus ----------------
  int t_now;

  task automatic nxt();
    @(negedge clock);
    t_now++;
  endtask

  task automatic adv(input int t);
    while (t_now < t) nxt();
  endtask

  task automatic lit_all0(input string tag);
    chk({tag, ".pId"}, 32'(sch.pId), 32'd0);
    chk({tag, ".freeze"}, 32'(sch.freeze), 32'd0);
    chk({tag, ".idle"}, 32'(sch.idle), 32'd0);
    chk({tag, ".ctx"}, 32'(sch.ctxSwitch), 32'd0);
    chk({tag, ".pcr"}, 32'(sch.pcReset), 32'd0);
  endtask

  initial begin
    sch.halt = 1'b0;
    sch.quantumLoad = 1'b0;
    sch.quantumIn = '0;
    sch.procStart = 1'b0;
    sch.procStartId = '0;
    sch.yieldReq = 1'b0;
    sch.exitReq = 1'b0;
    t_now = -3;

    adv(-1);
    lit_all0("rst");
    adv(0);
    reset = 1'b1;

    // self-resume every 16 RUN cycles
    adv(15); chk("q16.run15", 32'(sch.freeze), 32'd1 - 32'd1);
    adv(16); chk("q16.save", 32'(sch.freeze), 32'd1);
    adv(17); chk("q16.sel.ctx", 32'(sch.ctxSwitch), 32'd0);
    adv(18); chk("q16.resume", 32'(sch.freeze), 32'd0);

    // start id1, first dispatch requests a PC clear
    adv(20); sch.procStart = 1'b1; sch.procStartId = 1'b1;
    adv(21); sch.procStart = 1'b0;
    adv(34); chk("sw1.save", 32'(sch.freeze), 32'd1);
    adv(36); chk("sw1.pId", 32'(sch.pId), 32'd1);
             chk("sw1.ctx", 32'(sch.ctxSwitch), 32'd1);
             chk("sw1.pcr", 32'(sch.pcReset), 32'd1);
    adv(55); chk("sw0.pId", 32'(sch.pId), 32'd0);
             chk("sw0.pcr", 32'(sch.pcReset), 32'd0);

    // 10-cycle halt stretches the slice by 10
    adv(60); sch.halt = 1'b1;
    adv(65); chk("halt.freeze", 32'(sch.freeze), 32'd0);
    adv(70); sch.halt = 1'b0;
    adv(81); chk("halt.lastrun", 32'(sch.freeze), 32'd0);
    adv(82); chk("halt.save", 32'(sch.freeze), 32'd1);
    adv(84); chk("halt.sw.pId", 32'(sch.pId), 32'd1);

    // yield to 0, exit 0 -> 1, exit 1 -> IDLE, start 0 -> RESTORE with pcReset
    adv(86); sch.yieldReq = 1'b1;
    adv(87); sch.yieldReq = 1'b0;
    adv(91); sch.exitReq = 1'b1;
    adv(92); sch.exitReq = 1'b0;
    adv(94); chk("exit0.pId", 32'(sch.pId), 32'd1);
    adv(96); sch.exitReq = 1'b1;
    adv(97); sch.exitReq = 1'b0;
    adv(99); chk("idle.idle", 32'(sch.idle), 32'd1);
             chk("idle.freeze", 32'(sch.freeze), 32'd1);
             chk("idle.pId", 32'(sch.pId), 32'd1);
    adv(101); sch.procStart = 1'b1; sch.procStartId = 1'b0;
    adv(102); sch.procStart = 1'b0;
    adv(103); chk("wake.sel.idle", 32'(sch.idle), 32'd0);
    adv(104); chk("wake.pId", 32'(sch.pId), 32'd0);
              chk("wake.pcr", 32'(sch.pcReset), 32'd1);

    // quantum 0: current slice finishes, then no preemption
    adv(107); sch.quantumLoad = 1'b1; sch.quantumIn = 32'h0000_0000;
    adv(108); sch.quantumLoad = 1'b0;
    adv(121); chk("q0.save", 32'(sch.freeze), 32'd1);
    adv(125); sch.procStart = 1'b1; sch.procStartId = 1'b1;
    adv(126); sch.procStart = 1'b0;
    adv(170); chk("q0.nopreempt", 32'(sch.freeze), 32'd0);
              sch.yieldReq = 1'b1;
    adv(171); sch.yieldReq = 1'b0;
    adv(173); chk("q0.yield.pId", 32'(sch.pId), 32'd1);
              chk("q0.yield.pcr", 32'(sch.pcReset), 32'd1);

    // yield+exit+start on running id: process ends, not restarted
    adv(176); sch.yieldReq = 1'b1; sch.exitReq = 1'b1;
              sch.procStart = 1'b1; sch.procStartId = 1'b1;
    adv(177); sch.yieldReq = 1'b0; sch.exitReq = 1'b0; sch.procStart = 1'b0;
    adv(179); chk("combo.pId", 32'(sch.pId), 32'd0);
    adv(182); sch.yieldReq = 1'b1;
    adv(183); sch.yieldReq = 1'b0;
    adv(185); chk("combo.self.ctx", 32'(sch.ctxSwitch), 32'd0);
              chk("combo.self.freeze", 32'(sch.freeze), 32'd0);

    // reset during SELECT of a real switch
    adv(186); sch.procStart = 1'b1; sch.procStartId = 1'b1;
    adv(187); sch.procStart = 1'b0;
    adv(188); sch.yieldReq = 1'b1;
    adv(189); sch.yieldReq = 1'b0;
    adv(190); chk("midrst.presel", 32'(sch.freeze), 32'd1);
    #2 reset = 1'b0;
    #1 lit_all0("midrst");
    adv(192); reset = 1'b1;

    // quantum 3 via upper-bit-polluted load
    adv(193); sch.quantumLoad = 1'b1; sch.quantumIn = 32'hABCD_0003;
    adv(194); sch.quantumLoad = 1'b0;
    adv(208); chk("q3.save16", 32'(sch.freeze), 32'd1);
    adv(212); chk("q3.run3", 32'(sch.freeze), 32'd0);
    adv(213); chk("q3.save", 32'(sch.freeze), 32'd1);
    adv(230);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/process_scheduler.md
# process_scheduler

Round-robin, time-sliced scheduler that decides which hardware process context owns the single-cycle datapath. It drives the process-select index into the per-process program-counter bank, freezes the datapath during context switches and requests a PC clear when a newly started process is dispatched for the first time. It sits between the control unit (yield/exit/start requests) and the PC bank.

## Interface
- DATA_WIDTH, 32, width of the configuration data bus
- NPROCESS, 2, number of process contexts (2..16)
- QUANTUM_DEFAULT, 16, time-slice length in cycles after reset
- PID_W, $clog2(NPROCESS) (minimum 1), width of process ids

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- halt  in  1  datapath stall; freezes quantum countdown
- quantumLoad  in  1  load new quantum from quantumIn
- quantumIn  in  DATA_WIDTH  new quantum; only [15:0] used
- procStart  in  1  mark process procStartId alive and fresh
- procStartId  in  PID_W  process to start
- yieldReq  in  1  running process gives up its slice
- exitReq  in  1  running process terminates
- pId  out  PID_W  running process index (drives PC bank select)
- freeze  out  1  datapath must not update state this cycle
- pcReset  out  1  one-cycle request to clear PC of pId
- ctxSwitch  out  1  one-cycle pulse: pId changed this cycle
- idle  out  1  no process alive

## Operation
- State: alive[NPROCESS], fresh[NPROCESS], quantum reg (16 b), countdown (16 b), FSM {RUN, SAVE, SELECT, RESTORE, IDLE}.
- RUN: freeze=0. Countdown decrements each cycle with halt=0. Expiry when countdown==1 and decrementing, or yieldReq, or exitReq -> SAVE. exitReq clears alive[pId]. quantum==0: no preemption, only yield/exit leave RUN.
- SAVE: freeze=1; one cycle allows the outgoing PC write to complete. -> SELECT.
- SELECT: freeze=1. next = first alive index after pId in ascending order with wrap, current included last. No alive process -> IDLE. next==pId -> RUN, countdown reloaded, no ctxSwitch. Else -> RESTORE.
- RESTORE: pId<=next, ctxSwitch=1, freeze=1; pcReset=1 if fresh[next], then fresh[next] cleared. -> RUN with countdown reloaded.
- IDLE: freeze=1, idle=1, pId held. Any alive bit set -> SELECT next cycle (search starts after held pId).
- procStart on an already-alive id: ignored (fresh unchanged). procStart and exitReq on the same id same cycle: exit wins. exitReq beats yieldReq. Requests outside RUN: yieldReq/exitReq ignored; procStart always accepted.
- quantumLoad takes effect at the next countdown reload; current slice unaffected.

## Timing
- Reset (async assert, sync release): state RUN, pId=0, alive=000..1, fresh=0, quantum=QUANTUM_DEFAULT, countdown=QUANTUM_DEFAULT, freeze=0, pcReset=0, ctxSwitch=0, idle=0.
- Outputs are registered-state decodes; no combinational input->output path.
- Switch cost: 3 frozen cycles (SAVE, SELECT, RESTORE); self-resume costs 2 (SAVE, SELECT).
- Slice of Q with no stalls: exactly Q RUN cycles with freeze=0 before SAVE.
- Reset asserted mid-switch returns to reset values immediately; no partial pId update.

## Structure
- Shared package: FSM state encoding, PID_W derivation, QUANTUM_W=16.
- Sub-module rr_next_select: combinational wrap-around priority pick (alive mask, current id) -> next id, valid.

## Test plan
- Reset, no starts, Q=16: pId stays 0, freeze pulses 2 cycles every 16 RUN cycles, ctxSwitch never 1.
- procStart id1 at cycle 3: after 16 RUN cycles, SAVE/SELECT/RESTORE; RESTORE has pId=1, ctxSwitch=1, pcReset=1; next switch back to 0 has pcReset=0.
- halt high for 10 cycles in mid-slice: slice ends 10 cycles later; freeze stays 0 during halt.
- exitReq by pId 0 with id1 alive: switch to 1; then exitReq by 1: IDLE, idle=1, freeze=1; procStart id0 -> SELECT then RESTORE pId=0, pcReset=1.
- quantumLoad 0 during slice: current slice expires normally, thereafter no preemption; yieldReq triggers switch.
- Same-cycle yieldReq+exitReq+procStart(same id as running): process ends, alive cleared, not restarted.
